// File: rtl/alu_pipe_top_pkg.sv
// Shared opcode encoding and flag payload for the multi-lane pipelined ALU.
package pck_alu_pipe;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_SLL   = 5'd6,
    OP_SRL   = 5'd7,
    OP_SRA   = 5'd8,
    OP_SLT   = 5'd9,
    OP_SLTU  = 5'd10,
    OP_PASSA = 5'd11,
    OP_PASSB = 5'd12
  } alu_op_e;

  localparam alu_op_e ALU_NOP = OP_NOP;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_top_lane.sv
// One combinational ALU lane; flag outputs exist only when ALU_FLAGS_EN is defined.
module alu_lane
  import pck_alu_pipe::*;
#(
  parameter int unsigned BITS = 8
) (
  input  alu_op_e          i_op,
  input  logic [BITS-1:0]  i_a,
  input  logic [BITS-1:0]  i_b,
  output logic [BITS-1:0]  o_res_c
`ifdef ALU_FLAGS_EN
  , output alu_flags_t     o_flags_c
`endif
);

  localparam int unsigned SHW = $clog2(BITS);

  logic [SHW-1:0]  w_sh;
  logic [BITS-1:0] w_sum;
  logic [BITS-1:0] w_dif;

  assign w_sh  = i_b[SHW-1:0];
  assign w_sum = i_a + i_b;
  assign w_dif = i_a - i_b;

  always_comb begin
    o_res_c = '0;
    case (i_op)
      OP_ADD:   o_res_c = w_sum;
      OP_SUB:   o_res_c = w_dif;
      OP_AND:   o_res_c = i_a & i_b;
      OP_OR:    o_res_c = i_a | i_b;
      OP_XOR:   o_res_c = i_a ^ i_b;
      OP_SLL:   o_res_c = i_a << w_sh;
      OP_SRL:   o_res_c = i_a >> w_sh;
      OP_SRA:   o_res_c = BITS'($signed(i_a) >>> w_sh);
      OP_SLT:   o_res_c = {{(BITS-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU:  o_res_c = {{(BITS-1){1'b0}}, (i_a < i_b)};
      OP_PASSA: o_res_c = i_a;
      OP_PASSB: o_res_c = i_b;
      default:  o_res_c = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry/borrow recovered from the operand and result MSBs, no widened adder needed.
  logic w_ma, w_mb;
  assign w_ma = i_a[BITS-1];
  assign w_mb = i_b[BITS-1];

  always_comb begin
    o_flags_c   = '0;
    o_flags_c.z = (o_res_c == '0);
    o_flags_c.n = o_res_c[BITS-1];
    case (i_op)
      OP_ADD: begin
        o_flags_c.c = (w_ma & w_mb) | ((w_ma | w_mb) & ~w_sum[BITS-1]);
        o_flags_c.v = (w_ma == w_mb) && (w_sum[BITS-1] != w_ma);
      end
      OP_SUB: begin
        o_flags_c.c = ~((~w_ma & w_mb) | ((~w_ma | w_mb) & w_dif[BITS-1]));
        o_flags_c.v = (w_ma != w_mb) && (w_dif[BITS-1] != w_ma);
      end
      default: begin
        o_flags_c.c = 1'b0;
        o_flags_c.v = 1'b0;
      end
    endcase
  end
`endif

endmodule

// File: rtl/alu_pipe_top.sv
// Multi-lane pipelined ALU with global valid/ready stall; ALU_FLAGS_EN adds per-lane {N,V,C,Z}.
module alu_pipe_top
  import pck_alu_pipe::*;
#(
  parameter int unsigned BITS   = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [4:0]              i_sel_op,
  input  logic [LANES*BITS-1:0]   i_op_a,
  input  logic [LANES*BITS-1:0]   i_op_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*BITS-1:0]   o_res
`ifdef ALU_FLAGS_EN
  , output logic [LANES*4-1:0]    o_flags
`endif
);

  localparam int unsigned PD = STAGES - 1;
  localparam int unsigned DW = LANES * BITS;

  logic          r_v1;
  alu_op_e       r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [PD-1:0] r_pv;
  logic [DW-1:0] r_pres [PD];
  logic [DW-1:0] w_res;
  logic          w_stall;
`ifdef ALU_FLAGS_EN
  logic [LANES*4-1:0] r_pflg [PD];
  logic [LANES*4-1:0] w_flg;
`endif

  assign w_stall = r_pv[PD-1] && !i_ready;
  assign o_ready = !w_stall;
  assign o_valid = r_pv[PD-1];
  assign o_res   = r_pres[PD-1];
`ifdef ALU_FLAGS_EN
  assign o_flags = r_pflg[PD-1];
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_lane #(.BITS(BITS)) u_lane (
      .i_op    (r_op),
      .i_a     (r_a[k*BITS +: BITS]),
      .i_b     (r_b[k*BITS +: BITS]),
      .o_res_c (w_res[k*BITS +: BITS])
`ifdef ALU_FLAGS_EN
      , .o_flags_c (w_flg[k*4 +: 4])
`endif
    );
  end

  // Bubbles enter stage 2 with zeroed data so the output is 0 whenever invalid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_op <= ALU_NOP;
      r_a  <= '0;
      r_b  <= '0;
      r_pv <= '0;
      for (int i = 0; i < int'(PD); i++) begin
        r_pres[i] <= '0;
`ifdef ALU_FLAGS_EN
        r_pflg[i] <= '0;
`endif
      end
    end else if (!w_stall) begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_op <= alu_op_e'(i_sel_op);
        r_a  <= i_op_a;
        r_b  <= i_op_b;
      end
      r_pv[0]   <= r_v1;
      r_pres[0] <= r_v1 ? w_res : '0;
`ifdef ALU_FLAGS_EN
      r_pflg[0] <= r_v1 ? w_flg : '0;
`endif
      for (int i = 1; i < int'(PD); i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pres[i] <= r_pres[i-1];
`ifdef ALU_FLAGS_EN
        r_pflg[i] <= r_pflg[i-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_top.sv
// Directed self-checking bench for alu_pipe_top (BITS=8, LANES=2, STAGES=3); honours ALU_FLAGS_EN.
module tb_alu_pipe_top;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  sel_op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        in_ready;
  logic [15:0] res;
`ifdef ALU_FLAGS_EN
  logic [7:0]  flags;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  alu_pipe_top #(.BITS(8), .LANES(2), .STAGES(3)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_sel_op (sel_op),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .o_valid  (out_valid),
    .i_ready  (in_ready),
    .o_res    (res)
`ifdef ALU_FLAGS_EN
    , .o_flags (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [7:0]  flg;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    sel_op   = op;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    // {op, a(lane1,lane0), b(lane1,lane0), res, flags lane1/lane0 {N,V,C,Z}}
    vt[0]  = '{5'd1,  16'h01F0, 16'h0220, 16'h0310, 8'h02};
    vt[1]  = '{5'd2,  16'h0500, 16'h0701, 16'hFEFF, 8'h88};
    vt[2]  = '{5'd8,  16'h4080, 16'h010A, 16'h20E0, 8'h08};
    vt[3]  = '{5'd10, 16'hFF01, 16'h01FF, 16'h0001, 8'h10};
    vt[4]  = '{5'd9,  16'h01FF, 16'hFF01, 16'h0001, 8'h10};
    vt[5]  = '{5'd20, 16'h5555, 16'hAAAA, 16'h0000, 8'h11};
    vt[6]  = '{5'd6,  16'h0181, 16'h0709, 16'h8002, 8'h80};
    vt[7]  = '{5'd7,  16'hF080, 16'h040F, 16'h0F01, 8'h00};
    vt[8]  = '{5'd3,  16'hAAF0, 16'h553C, 16'h0030, 8'h10};
    vt[9]  = '{5'd4,  16'h00F0, 16'h000F, 16'h00FF, 8'h18};
    vt[10] = '{5'd5,  16'hAAFF, 16'hAA0F, 16'h00F0, 8'h18};
    vt[11] = '{5'd1,  16'hFF7F, 16'h0101, 16'h0080, 8'h3C};
    vt[12] = '{5'd2,  16'h1080, 16'h1001, 16'h007F, 8'h36};
    vt[13] = '{5'd11, 16'h3412, 16'h9999, 16'h3412, 8'h00};
    vt[14] = '{5'd12, 16'h7777, 16'hCDAB, 16'hCDAB, 8'h88};
    vt[15] = '{5'd0,  16'h5555, 16'hAAAA, 16'h0000, 8'h11};

    rst = 1'b1;
    in_ready = 1'b1;
    drive(1'b0, 5'd0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_res",   32'(res),       32'd0);
      chk("idle_ready", 32'(out_ready), 32'd1);
`ifdef ALU_FLAGS_EN
      chk("idle_flags", 32'(flags),     32'd0);
`endif
    end

    // Back-to-back stream: vector k driven before edge k, result after edge k+2.
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drive(1'b1, vt[c].op, vt[c].a, vt[c].b);
      else        drive(1'b0, 5'd0, 16'h0, 16'h0);
      tick();
      if (c < 2) begin
        chk("lat_valid", 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("vec%0d_valid", c-2), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_res", c-2),   32'(res),       32'(vt[c-2].res));
`ifdef ALU_FLAGS_EN
        chk($sformatf("vec%0d_flags", c-2), 32'(flags),     32'(vt[c-2].flg));
`endif
      end
    end
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    tick();
    chk("drain_res", 32'(res), 32'd0);

    // Backpressure: three in flight, four stalled edges, release with new input on same edge.
    drive(1'b1, 5'd1, 16'h0101, 16'h0101); tick();
    drive(1'b1, 5'd1, 16'h0202, 16'h0202); tick();
    drive(1'b1, 5'd1, 16'h0303, 16'h0303); tick();
    chk("st_first_valid", 32'(out_valid), 32'd1);
    chk("st_first_res",   32'(res),       32'h0202);
    in_ready = 1'b0;
    drive(1'b1, 5'd1, 16'h0404, 16'h0404);
    #1;
    chk("st_ready_low", 32'(out_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_hold_valid", 32'(out_valid), 32'd1);
      chk("st_hold_res",   32'(res),       32'h0202);
      chk("st_hold_ready", 32'(out_ready), 32'd0);
    end
    in_ready = 1'b1;
    #1;
    chk("st_release_ready", 32'(out_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 16'h0, 16'h0);
    chk("st_out2", 32'(res), 32'h0404);
    tick();
    chk("st_out3", 32'(res), 32'h0606);
    tick();
    chk("st_out4_valid", 32'(out_valid), 32'd1);
    chk("st_out4", 32'(res), 32'h0808);
    tick();
    chk("st_empty", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight: nothing may emerge afterwards.
    drive(1'b1, 5'd12, 16'h0000, 16'h7777); tick();
    drive(1'b1, 5'd12, 16'h0000, 16'h6666); tick();
    drive(1'b0, 5'd0, 16'h0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res",   32'(res),       32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_stale_valid", 32'(out_valid), 32'd0);
      chk("rst_no_stale_res",   32'(res),       32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
